// File: rtl/cache_line_mem_ctrl_if.sv
// Request, response and RAM-port bundle for the line-transfer engine.
// The engine side takes the slave modport; the requester/RAM side takes master.
interface cache_line_mem_ctrl_if #(
    parameter int LINE_W = 128,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BPW = WORD_W / 8;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_fill_i;
    logic                  req_wb_i;
    logic [ADDR_W-1:0]     fill_addr_i;
    logic [ADDR_W-1:0]     wb_addr_i;
    logic [LINE_W-1:0]     wb_line_i;
    logic [LINE_W/8-1:0]   wb_be_i;
    logic                  resp_valid_o;
    logic [LINE_W-1:0]     resp_line_o;
    logic                  busy_o;
    logic                  ram_read_o;
    logic [ADDR_W-1:0]     ram_read_addr_o;
    logic [WORD_W-1:0]     ram_data_i;
    logic [ADDR_W-1:0]     ram_write_addr_o;
    logic [WORD_W-1:0]     ram_data_o;
    logic [BPW-1:0]        wr_strb_o;

    modport slave (
        input  req_valid_i, req_fill_i, req_wb_i, fill_addr_i, wb_addr_i,
               wb_line_i, wb_be_i, ram_data_i,
        output req_ready_o, resp_valid_o, resp_line_o, busy_o, ram_read_o,
               ram_read_addr_o, ram_write_addr_o, ram_data_o, wr_strb_o
    );

    modport master (
        output req_valid_i, req_fill_i, req_wb_i, fill_addr_i, wb_addr_i,
               wb_line_i, wb_be_i, ram_data_i,
        input  req_ready_o, resp_valid_o, resp_line_o, busy_o, ram_read_o,
               ram_read_addr_o, ram_write_addr_o, ram_data_o, wr_strb_o
    );
endinterface

// File: rtl/cache_line_mem_ctrl.sv
// Line-transfer engine: a line request becomes WORDS single-word RAM writes
// (writeback) followed by WORDS reads (fill) reassembled into resp_line_o.
module cache_line_mem_ctrl #(
    parameter int LINE_W = 128,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cache_line_mem_ctrl_if.slave  bus
);
    localparam int WORDS   = LINE_W / WORD_W;
    localparam int BPW     = WORD_W / 8;
    localparam int CNT_MAX = (WORDS > RD_LAT) ? WORDS : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'((LINE_W / 8) - 1));

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                          r_state, w_next;
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_fill;
    logic [ADDR_W-1:0]               r_wb_base, r_fill_base;
    logic [LINE_W-1:0]               r_line, r_resp_line;
    logic [LINE_W/8-1:0]             r_be;
    logic [ADDR_W-1:0]               r_waddr, r_raddr;
    logic [WORD_W-1:0]               r_wdata;
    logic [RD_LAT-1:0]               r_vld_pipe;
    logic [RD_LAT-1:0][CNT_W-1:0]    r_idx_pipe;

    logic                w_ready, w_accept, w_rd, w_last_word, w_last_drain;
    logic [ADDR_W-1:0]   w_waddr, w_raddr;
    logic [WORD_W-1:0]   w_wdata;

    assign w_ready      = (r_state == S_IDLE) & rst_ni;
    assign w_accept     = bus.req_valid_i & w_ready;
    assign w_rd         = (r_state == S_READ);
    assign w_last_word  = (r_cnt == CNT_W'(WORDS - 1));
    assign w_last_drain = (r_cnt == CNT_W'(RD_LAT - 1));
    assign w_waddr      = r_wb_base + ADDR_W'(r_cnt) * ADDR_W'(BPW);
    assign w_raddr      = r_fill_base + ADDR_W'(r_cnt) * ADDR_W'(BPW);
    assign w_wdata      = r_line[r_cnt*WORD_W +: WORD_W];

    // State register; r_cnt restarts on every state change.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)
                         w_next = bus.req_wb_i ? S_WRITE : (bus.req_fill_i ? S_READ : S_DONE);
            S_WRITE: if (w_last_word) w_next = r_fill ? S_READ : S_DONE;
            S_READ:  if (w_last_word) w_next = S_DRAIN;
            S_DRAIN: if (w_last_drain) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, held-output shadows and the read-return pipeline.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fill      <= 1'b0;
            r_wb_base   <= '0;
            r_fill_base <= '0;
            r_line      <= '0;
            r_be        <= '0;
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_wdata     <= '0;
            r_resp_line <= '0;
            r_vld_pipe  <= '0;
            r_idx_pipe  <= '0;
        end else begin
            if (w_accept) begin
                r_fill      <= bus.req_fill_i;
                r_wb_base   <= bus.wb_addr_i & ADDR_MASK;
                r_fill_base <= bus.fill_addr_i & ADDR_MASK;
                r_line      <= bus.wb_line_i;
                r_be        <= bus.wb_be_i;
            end
            if (r_state == S_WRITE) begin
                r_waddr <= w_waddr;
                r_wdata <= w_wdata;
            end
            if (w_rd) r_raddr <= w_raddr;
            r_vld_pipe[0] <= w_rd;
            r_idx_pipe[0] <= r_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_idx_pipe[i] <= r_idx_pipe[i-1];
            end
            // Each word lands in its own slot, so the line is never shifted.
            if (r_vld_pipe[RD_LAT-1])
                r_resp_line[r_idx_pipe[RD_LAT-1]*WORD_W +: WORD_W] <= bus.ram_data_i;
        end
    end

    always_comb begin
        bus.req_ready_o      = w_ready;
        bus.busy_o           = (r_state != S_IDLE);
        bus.resp_valid_o     = (r_state == S_DONE);
        bus.ram_read_o       = w_rd;
        bus.ram_read_addr_o  = w_rd ? w_raddr : r_raddr;
        bus.ram_write_addr_o = (r_state == S_WRITE) ? w_waddr : r_waddr;
        bus.ram_data_o       = (r_state == S_WRITE) ? w_wdata : r_wdata;
        bus.wr_strb_o        = (r_state == S_WRITE) ? r_be[r_cnt*BPW +: BPW] : '0;
        bus.resp_line_o      = r_resp_line;
    end
endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Bench for cache_line_mem_ctrl: two configurations (128/32 RD_LAT=1 and
// 256/64 RD_LAT=2), each with a byte RAM and a shadow memory as the reference.
module tb_cache_line_mem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   tests = 0;
    int   fails = 0;

    cache_line_mem_ctrl_if #(.LINE_W(128), .WORD_W(32), .ADDR_W(32)) bus_a ();
    cache_line_mem_ctrl_if #(.LINE_W(256), .WORD_W(64), .ADDR_W(32)) bus_b ();

    cache_line_mem_ctrl #(.LINE_W(128), .WORD_W(32), .ADDR_W(32), .RD_LAT(1))
        dut_a (.clk_i(clk), .rst_ni(rst_a), .bus(bus_a.slave));
    cache_line_mem_ctrl #(.LINE_W(256), .WORD_W(64), .ADDR_W(32), .RD_LAT(2))
        dut_b (.clk_i(clk), .rst_ni(rst_b), .bus(bus_b.slave));

    // RAM (written by the DUT) and shadow (written by the model), 1 KiB each,
    // addressed modulo 1024.
    bit [7:0]      ram_a [1024];
    bit [7:0]      ram_b [1024];
    bit [7:0]      sh_a  [1024];
    bit [7:0]      sh_b  [1024];
    logic          ram_init = 1'b0;
    logic [63:0]   p_b;
    logic [255:0]  exp_line [2];

    typedef struct {
        logic         ready, busy, resp, rd;
        logic [31:0]  raddr, waddr;
        logic [63:0]  wdata;
        logic [7:0]   strb;
        logic [255:0] line;
    } obs_t;

    function automatic int ix(input logic [31:0] a);
        return int'(a[9:0]);
    endfunction

    // Words 0x50..0x5C hold 0x13, 0x93, 0x113, 0x193; other bytes a pattern.
    function automatic bit [7:0] init_byte(input int a);
        bit [31:0] w;
        if (a >= 'h50 && a < 'h60) begin
            w = 32'h13 + 32'((a - 'h50) / 4) * 32'h80;
            return w[(a % 4)*8 +: 8];
        end
        return 8'(a) ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word_a(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = ram_a[ix(a + 32'(i))];
        return w;
    endfunction

    function automatic logic [63:0] word_b(input logic [31:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = ram_b[ix(a + 32'(i))];
        return w;
    endfunction

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 1024; i++) begin
                ram_a[i] <= init_byte(i);
                ram_b[i] <= init_byte(i);
            end
            ram_init <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus_a.wr_strb_o[i])
                    ram_a[ix(bus_a.ram_write_addr_o + 32'(i))] <= bus_a.ram_data_o[i*8 +: 8];
            for (int i = 0; i < 8; i++)
                if (bus_b.wr_strb_o[i])
                    ram_b[ix(bus_b.ram_write_addr_o + 32'(i))] <= bus_b.ram_data_o[i*8 +: 8];
        end
        bus_a.ram_data_i <= bus_a.ram_read_o ? word_a(bus_a.ram_read_addr_o) : 32'h0;
        p_b              <= bus_b.ram_read_o ? word_b(bus_b.ram_read_addr_o) : 64'h0;
        bus_b.ram_data_i <= p_b;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic wb, input logic fl,
                         input logic [31:0] wa, input logic [31:0] fa,
                         input logic [255:0] line, input logic [31:0] be);
        if (sel == 0) begin
            bus_a.req_valid_i = v;  bus_a.req_wb_i = wb;  bus_a.req_fill_i = fl;
            bus_a.wb_addr_i = wa;   bus_a.fill_addr_i = fa;
            bus_a.wb_line_i = line[127:0];  bus_a.wb_be_i = be[15:0];
        end else begin
            bus_b.req_valid_i = v;  bus_b.req_wb_i = wb;  bus_b.req_fill_i = fl;
            bus_b.wb_addr_i = wa;   bus_b.fill_addr_i = fa;
            bus_b.wb_line_i = line; bus_b.wb_be_i = be;
        end
    endtask

    task automatic sample(input int sel, output obs_t o);
        if (sel == 0) begin
            o.ready = bus_a.req_ready_o;  o.busy = bus_a.busy_o;
            o.resp  = bus_a.resp_valid_o; o.rd   = bus_a.ram_read_o;
            o.raddr = bus_a.ram_read_addr_o;  o.waddr = bus_a.ram_write_addr_o;
            o.wdata = 64'(bus_a.ram_data_o);  o.strb  = 8'(bus_a.wr_strb_o);
            o.line  = 256'(bus_a.resp_line_o);
        end else begin
            o.ready = bus_b.req_ready_o;  o.busy = bus_b.busy_o;
            o.resp  = bus_b.resp_valid_o; o.rd   = bus_b.ram_read_o;
            o.raddr = bus_b.ram_read_addr_o;  o.waddr = bus_b.ram_write_addr_o;
            o.wdata = bus_b.ram_data_o;       o.strb  = bus_b.wr_strb_o;
            o.line  = bus_b.resp_line_o;
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    // One request from a negedge with the DUT idle; returns at the negedge of
    // the cycle after resp_valid_o, so a following call is back-to-back.
    task automatic run_req(input int sel, input logic wb, input logic fl,
                           input logic [31:0] wa, input logic [31:0] fa,
                           input logic [255:0] line, input logic [31:0] be, input bit hold);
        int           W   = 4;
        int           bpw = (sel != 0) ? 8 : 4;
        int           rdl = (sel != 0) ? 2 : 1;
        int           lb  = (sel != 0) ? 32 : 16;
        logic [31:0]  wbase = wa & ~32'(lb - 1);
        logic [31:0]  fbase = fa & ~32'(lb - 1);
        int           L   = (wb ? W : 0) + (fl ? W + rdl : 0) + 1;
        int           rs  = wb ? W + 1 : 1;
        logic [255:0] wm  = (sel != 0) ? 256'hFFFF_FFFF_FFFF_FFFF : 256'hFFFF_FFFF;
        logic [31:0]  bm  = (sel != 0) ? 32'hFF : 32'hF;
        logic [255:0] got, want;
        obs_t         o;
        if (!wb) be = '0;
        // Reference: apply dirty bytes to the shadow, then read the fill line.
        for (int k = 0; k < W; k++)
            for (int j = 0; j < bpw; j++)
                if (be[k*bpw + j]) begin
                    if (sel == 0) sh_a[ix(wbase + 32'(k*bpw + j))] = line[(k*bpw + j)*8 +: 8];
                    else          sh_b[ix(wbase + 32'(k*bpw + j))] = line[(k*bpw + j)*8 +: 8];
                end
        if (fl) begin
            want = '0;
            for (int i = 0; i < lb; i++)
                want[i*8 +: 8] = (sel == 0) ? sh_a[ix(fbase + 32'(i))] : sh_b[ix(fbase + 32'(i))];
            exp_line[sel] = want;
        end
        sample(sel, o);
        chk("ready_before_req", o.ready, 1);
        drive(sel, 1'b1, wb, fl, wa, fa, line, be);
        @(posedge clk);
        #1 drive(sel, hold, 1'($urandom()), 1'($urandom()), $urandom(), $urandom(), rnd_line(), $urandom());
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            sample(sel, o);
            chk("busy", o.busy, 1);
            chk("ready_while_busy", o.ready, 0);
            chk("resp_valid", o.resp, (c == L));
            if (wb && c <= W) begin
                chk("wr_strb", o.strb, (be >> ((c-1)*bpw)) & bm);
                chk("wr_addr", o.waddr, wbase + 32'((c-1)*bpw));
                chk("wr_data", o.wdata, (line >> ((c-1)*bpw*8)) & wm);
            end else
                chk("wr_strb_idle", o.strb, 0);
            if (fl && c >= rs && c < rs + W) begin
                chk("ram_read", o.rd, 1);
                chk("rd_addr", o.raddr, fbase + 32'((c-rs)*bpw));
            end else
                chk("ram_read_idle", o.rd, 0);
        end
        chk("resp_line", o.line, exp_line[sel]);
        @(negedge clk);
        sample(sel, o);
        chk("ready_after", o.ready, 1);
        chk("busy_after", o.busy, 0);
        chk("resp_after", o.resp, 0);
        if (hold) drive(sel, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        if (wb) begin
            got = '0;  want = '0;
            for (int i = 0; i < lb; i++) begin
                got[i*8 +: 8]  = (sel == 0) ? ram_a[ix(wbase + 32'(i))] : ram_b[ix(wbase + 32'(i))];
                want[i*8 +: 8] = (sel == 0) ? sh_a[ix(wbase + 32'(i))]  : sh_b[ix(wbase + 32'(i))];
            end
            chk("ram_readback", got, want);
        end
    endtask

    initial begin
        obs_t o;
        for (int i = 0; i < 1024; i++) begin
            sh_a[i] = init_byte(i);
            sh_b[i] = init_byte(i);
        end
        exp_line[0] = '0;
        exp_line[1] = '0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s, o);
            chk("rst_ready", o.ready, 0);
            chk("rst_busy", o.busy, 0);
            chk("rst_resp", o.resp, 0);
            chk("rst_read", o.rd, 0);
            chk("rst_strb", o.strb, 0);
            chk("rst_addrs", {o.raddr, o.waddr}, 0);
            chk("rst_wdata", o.wdata, 0);
            chk("rst_line", o.line, 0);
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);

        // Fill only from 0x50.
        run_req(0, 0, 1, 0, 32'h50, 0, 0, 0);
        sample(0, o);
        chk("fill_0x50_line", o.line, 256'h00000193_00000113_00000093_00000013);
        // Full writeback at 0, then a one-byte dirty mask.
        run_req(0, 1, 0, 32'h0, 0, 256'h00000003_00000002_00001100_00000004, 32'hFFFF, 0);
        run_req(0, 1, 0, 32'h0, 0, 256'h0F, 32'h0001, 0);
        // Same-line and other-line combined requests on the wide instance.
        run_req(1, 1, 1, 32'h0, 32'h90, rnd_line(), 32'hFFFF_FFFF, 0);
        run_req(1, 1, 1, 32'h44, 32'h40, rnd_line(), $urandom(), 0);
        // Unaligned high fill address, no-op on both.
        run_req(1, 0, 1, 0, 32'h7FFF_FFE7, 0, 0, 0);
        run_req(0, 0, 0, 0, 0, 0, 0, 0);
        run_req(1, 0, 0, 0, 0, 0, 0, 0);
        // Requester holds valid through a fill.
        run_req(0, 0, 1, 0, 32'h120, 0, 0, 1);

        // Reset during the second READ cycle.
        drive(0, 1, 0, 1, 0, 32'h200, 0, 0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        sample(0, o);
        chk("abort_read", o.rd, 0);
        chk("abort_busy", o.busy, 0);
        chk("abort_resp", o.resp, 0);
        chk("abort_ready_in_rst", o.ready, 0);
        chk("abort_raddr", o.raddr, 0);
        chk("abort_line", o.line, 0);
        exp_line[0] = '0;
        rst_a = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sample(0, o);
            chk("post_abort_idle", {o.rd, o.resp, o.ready, o.strb}, {1'b0, 1'b0, 1'b1, 8'h0});
        end

        // Random traffic, with random gaps including back-to-back.
        for (int n = 0; n < 40; n++) begin
            int sel = int'($urandom_range(0, 1));
            run_req(sel, 1'($urandom()), 1'($urandom()), $urandom(), $urandom(),
                    rnd_line(), $urandom(), bit'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
